// File: rtl/mini_cpu_result_monitor_if.sv
// Result-monitor port bundle: capture inputs, read port, status and counters.
// The slave side is the monitor; the master side is whoever drives and drains it.
interface mini_cpu_result_monitor_if #(
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    // capture side
    logic          STROBE;
    logic [7:0]    RESULT;
    logic          OVERFLOW;
    // read port
    logic          RD_VALID;
    logic          RD_READY;
    logic [8:0]    RD_DATA;
    // status / counters
    logic [CW-1:0] COUNT;
    logic          FULL;
    logic [7:0]    OVF_CNT;
    logic [7:0]    DROP_CNT;
    logic          CLR_CNT;

    modport slave (
        input  STROBE, RESULT, OVERFLOW, RD_READY, CLR_CNT,
        output RD_VALID, RD_DATA, COUNT, FULL, OVF_CNT, DROP_CNT
    );

    modport master (
        output STROBE, RESULT, OVERFLOW, RD_READY, CLR_CNT,
        input  RD_VALID, RD_DATA, COUNT, FULL, OVF_CNT, DROP_CNT
    );
endinterface

// File: rtl/mini_cpu_result_monitor.sv
// MiniCPU result monitor: samples {OVERFLOW, RESULT} on each instruction
// strobe into a small FIFO drained over a valid/ready port, and keeps
// saturating overflow/drop counters. Every output comes from a register.
module mini_cpu_result_monitor #(
    parameter int DEPTH       = 8,
    parameter bit CHANGE_ONLY = 1'b0
) (
    input logic                     CLK,
    input logic                     RST_N,
    mini_cpu_result_monitor_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // storage and pointers
    logic [8:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] rd_ptr_inc;

    // occupancy, kept as its own register rather than derived from pointers
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_nxt;
    logic          valid_q;
    logic          full_q;

    // head entry is held in a register so RD_DATA has a defined reset value
    // even though the storage array is never reset
    logic [8:0]    head_q;

    // last pushed sample, used by change-only filtering
    logic [8:0]    last_q;
    logic          last_vld;

    logic [7:0]    ovf_q;
    logic [7:0]    drop_q;

    // per-cycle decisions
    logic [8:0]    sample;
    logic          same_as_last;
    logic          cand;
    logic          pop;
    logic          push;
    logic          drop;
    logic          ovf_inc;

    // Saturating 8-bit counter step. A clear discards the old value but still
    // lets a same-cycle increment land, so clear+increment yields 1.
    function automatic logic [7:0] sat_next(input logic [7:0] cur,
                                            input logic       inc,
                                            input logic       clr);
        logic [7:0] r;
        if (clr)
            r = inc ? 8'd1 : 8'd0;
        else if (inc && cur != 8'hFF)
            r = cur + 8'd1;
        else
            r = cur;
        return r;
    endfunction

    // Capture / push / pop / drop decisions for this cycle.
    always_comb begin
        sample       = {bus.OVERFLOW, bus.RESULT};
        same_as_last = last_vld && (sample == last_q);
        cand         = bus.STROBE && !(CHANGE_ONLY && same_as_last);
        // pop is qualified by the registered valid, so a push into an empty
        // FIFO is never popped in the same cycle
        pop          = valid_q && bus.RD_READY;
        // a full FIFO still accepts when the head leaves in the same cycle
        push         = cand && (!full_q || pop);
        drop         = cand && !push;
        ovf_inc      = push && sample[8];
        rd_ptr_inc   = rd_ptr + PW'(1);
    end

    // Next occupancy: +1 push only, -1 pop only, else unchanged.
    always_comb begin
        count_nxt = count_q;
        if (push && !pop)
            count_nxt = count_q + CW'(1);
        else if (pop && !push)
            count_nxt = count_q - CW'(1);
    end

    // Storage write; contents are deliberately not reset.
    always_ff @(posedge CLK) begin
        if (push)
            mem[wr_ptr] <= sample;
    end

    // Pointers, occupancy and registered status flags.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            full_q  <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr_inc;
            count_q <= count_nxt;
            valid_q <= (count_nxt != '0);
            full_q  <= (count_nxt == CW'(DEPTH));
        end
    end

    // Head register: takes the new sample when it becomes the only entry,
    // otherwise follows the storage entry behind the one being popped.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            head_q <= 9'h000;
        end else if (push && (count_q == '0 || (pop && count_q == CW'(1)))) begin
            head_q <= sample;
        end else if (pop && count_q > CW'(1)) begin
            head_q <= mem[rd_ptr_inc];
        end
    end

    // Last pushed sample and its valid flag.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            last_q   <= 9'h000;
            last_vld <= 1'b0;
        end else if (push) begin
            last_q   <= sample;
            last_vld <= 1'b1;
        end
    end

    // Saturating overflow and drop counters with synchronous clear.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ovf_q  <= 8'd0;
            drop_q <= 8'd0;
        end else begin
            ovf_q  <= sat_next(ovf_q, ovf_inc, bus.CLR_CNT);
            drop_q <= sat_next(drop_q, drop, bus.CLR_CNT);
        end
    end

    assign bus.RD_VALID = valid_q;
    assign bus.RD_DATA  = head_q;
    assign bus.COUNT    = count_q;
    assign bus.FULL     = full_q;
    assign bus.OVF_CNT  = ovf_q;
    assign bus.DROP_CNT = drop_q;

endmodule

// File: doc/mini_cpu_result_monitor.md
# mini_cpu_result_monitor

Capture block for the MiniCPU output side. It samples `{OVERFLOW, RESULT}` each time the instruction source marks an instruction boundary, and buffers the samples in a small FIFO. It exposes them on a valid/ready read port, so a checker, UART bridge or bench can drain results at its own rate. It also keeps saturating overflow and drop counters, giving a sticky record of CPU overflow events and lost samples.

## Interface

Parameters:
- `DEPTH`, 8: FIFO entries; power of two, 2..64.
- `CHANGE_ONLY`, 0: when 1, a strobed sample is captured only if it differs from the last captured sample.

Ports:
- `CLK` input 1: single clock, rising edge.
- `RST_N` input 1: reset; asynchronous, active-low.
- `STROBE` input 1: sample request, one cycle per instruction boundary.
- `RESULT` input 8: MiniCPU `RESULT`.
- `OVERFLOW` input 1: MiniCPU `OVERFLOW`.
- `RD_VALID` output 1: head entry available.
- `RD_READY` input 1: consumer accepts head.
- `RD_DATA` output 9: `{OVERFLOW, RESULT}` of head entry.
- `COUNT` output log2(DEPTH)+1: entries held.
- `FULL` output 1: `COUNT == DEPTH`.
- `OVF_CNT` output 8: captured samples with OVERFLOW=1; saturates at 255.
- `DROP_CNT` output 8: samples lost to full FIFO; saturates at 255.
- `CLR_CNT` input 1: synchronous clear of `OVF_CNT` and `DROP_CNT`.

## Operation

- **Capture:** on a rising edge with `STROBE`=1, form `S = {OVERFLOW, RESULT}`.
  - `CHANGE_ONLY`=1: skip S if `S == LAST`. `LAST` is a register of the last *pushed* sample.
  - `LAST` has a valid flag, cleared by reset, so the first strobe after reset is always a candidate.
- **Push:** a candidate is written if the FIFO is not full, or if a pop occurs in the same cycle.
  - On push: `LAST <= S`. If `S[8]`=1, `OVF_CNT` increments, saturating at 255.
- **Drop:** a candidate that is not pushed increments `DROP_CNT`, saturating at 255. The FIFO contents are unchanged.
- **Pop:** occurs when `RD_VALID && RD_READY`. It advances the read pointer.
  - `RD_DATA` is the head entry and is stable while `RD_VALID`=1 and no pop occurs.
- **Pointers:** read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - `COUNT` is tracked separately: +1 on push only, -1 on pop only, unchanged on both or neither.
- **CLR_CNT:**
  - `CLR_CNT` alone zeroes both counters.
  - `CLR_CNT` with an increment in the same cycle: the counter becomes 1; the clear wins over the old value.
  - FIFO contents and `LAST` are unaffected.
- **Reset:**
  - Asserting `RST_N`=0 at any time, including mid-drain, immediately clears: pointers, `COUNT`=0, `RD_VALID`=0, `FULL`=0, `OVF_CNT`=0, `DROP_CNT`=0, `LAST` valid=0.
  - `RD_DATA` reset value is 9'h000.
  - FIFO storage RAM is not reset.
- Each state field of `RD_DATA` and the status outputs is driven directly from registers or RAM; there are no combinational paths from `STROBE`, `RESULT`, `OVERFLOW`, `CLR_CNT` or `RD_READY` to any output.

## Timing

- **Capture latency:** a sample strobed at edge N is visible at edge N+1 when the FIFO was empty; that is, `RD_VALID`=1 and `RD_DATA`=S after edge N.
- **Throughput:** one push and one pop per cycle sustained.
- **Push/pop boundaries:**
  - Simultaneous push and pop with the FIFO full: no drop; `COUNT` stays DEPTH.
  - Simultaneous push and pop with `COUNT`=1: `RD_DATA` moves to the new sample at the next edge; `RD_VALID` stays 1.
  - Push with the FIFO empty while `RD_READY`=1: no pop in that cycle, since `RD_VALID` was 0. The pop happens in the following cycle.
- **Status updates:** `FULL` and `COUNT` update on the same edge as the push or pop that changes them.
- **Reset release:** after `RST_N` deasserts, the first strobe is accepted at the first rising edge.

## Test plan

1. **Single capture.** Reset, then `STROBE` one cycle with RESULT=8'h5A, OVERFLOW=0 -> next cycle `RD_VALID`=1, `RD_DATA`=9'h05A, `COUNT`=1. Pulse `RD_READY` -> `RD_VALID`=0, `COUNT`=0.
2. **Fill, overflow and drain.** DEPTH=8, `RD_READY`=0, 10 strobes with RESULT=0..9 -> `FULL`=1, `COUNT`=8, `DROP_CNT`=2. Drain -> `RD_DATA` sequence 0..7 in order, then `RD_VALID`=0.
3. **Full with concurrent pop.** FIFO full, `STROBE` and `RD_READY` asserted together for 20 cycles with incrementing data -> `DROP_CNT` unchanged, `COUNT`=8 throughout, output order strictly increasing. This also covers pointer wrap-around.
4. **Overflow counting and clear.** 3 strobes with OVERFLOW=1 -> `OVF_CNT`=3. `CLR_CNT` together with a fourth OVERFLOW=1 strobe -> `OVF_CNT`=1. 300 OVERFLOW=1 strobes while draining -> `OVF_CNT`=255.
5. **CHANGE_ONLY=1.** Strobe samples 9'h011, 9'h011, 9'h111, 9'h111, 9'h011 -> exactly 3 entries captured: 011, 111, 011. No drops.
6. **Mid-operation reset.** With 5 entries queued, pulse `RST_N`=0 between clock edges -> `RD_VALID`, `COUNT`, `FULL` and both counters go to 0 immediately, without waiting for a clock edge. A subsequent strobe of 9'h0A5 is read back as the sole entry.
